// File: rtl/mult_operand_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_operand_dispatcher_if
// Brief    : Operand, multiplier and result signals of the operand dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_operand_dispatcher_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   op_valid_in;
    logic                   op_ready_out;
    logic [WIDTH-1:0]       multiplicand_data_in;
    logic [WIDTH-1:0]       multiplier_data_in;
    logic [WIDTH-1:0]       multiplicand_out;
    logic [WIDTH-1:0]       multiplier_out;
    logic                   start_out;
    logic                   done_in;
    logic                   overflow_in;
    logic [2*WIDTH-1:0]     product_in;
    logic                   result_valid_out;
    logic                   result_ready_in;
    logic [2*WIDTH-1:0]     result_out;
    logic                   result_overflow_out;
    logic [CW-1:0]          pending_count_out;
    logic                   timeout_out;

    // slave: the dispatcher; master: upstream source, multiplier and result sink
    modport slave (
        input  op_valid_in, multiplicand_data_in, multiplier_data_in,
        input  done_in, overflow_in, product_in, result_ready_in,
        output op_ready_out, multiplicand_out, multiplier_out, start_out,
        output result_valid_out, result_out, result_overflow_out,
        output pending_count_out, timeout_out
    );

    modport master (
        output op_valid_in, multiplicand_data_in, multiplier_data_in,
        output done_in, overflow_in, product_in, result_ready_in,
        input  op_ready_out, multiplicand_out, multiplier_out, start_out,
        input  result_valid_out, result_out, result_overflow_out,
        input  pending_count_out, timeout_out
    );
endinterface
`default_nettype wire

// File: rtl/mult_operand_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : mult_operand_dispatcher
// Brief    : Queues operand pairs and feeds them one job at a time to a
//            sequential multiplier; optional BUSY watchdog under
//            MULT_DISPATCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_operand_dispatcher #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic                clock,
    input  wire logic                reset_in,
    mult_operand_dispatcher_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_BUSY = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     mcand_mem_q [DEPTH];
    logic [WIDTH-1:0]     mcand_mem_d [DEPTH];
    logic [WIDTH-1:0]     mplier_mem_q [DEPTH];
    logic [WIDTH-1:0]     mplier_mem_d [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 result_ovf_q, result_ovf_d;
    logic                 timeout_q, timeout_d;
    logic                 done_prev_q, done_prev_d;

    logic w_op_ready;
    logic w_push;
    logic w_pop;
    logic w_done_rise;
    logic w_timeout;

    assign w_op_ready  = (count_q != c_FULL);
    assign w_push      = bus.op_valid_in & w_op_ready;
    assign w_pop       = (state_q == c_IDLE) && (count_q != '0);
    // Edge detect makes a done level left over from before BUSY harmless
    assign w_done_rise = (state_q == c_BUSY) && bus.done_in && !done_prev_q;

`ifdef MULT_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign w_timeout = (state_q == c_BUSY) && !w_done_rise && (tmo_cnt_q == c_TMO_LAST);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == c_LOAD) begin
            tmo_cnt_d = '0;
        end else if (state_q == c_BUSY) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_pop) state_d = c_LOAD;
            c_LOAD:  state_d = c_BUSY;
            c_BUSY:  if (w_done_rise || w_timeout) state_d = c_HOLD;
            c_HOLD:  if (bus.result_ready_in) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        bus.op_ready_out        = w_op_ready;
        bus.start_out           = (state_q == c_BUSY);
        bus.result_valid_out    = (state_q == c_HOLD);
        bus.multiplicand_out    = mcand_q;
        bus.multiplier_out      = mplier_q;
        bus.result_out          = result_q;
        bus.result_overflow_out = result_ovf_q;
        bus.timeout_out         = timeout_q;
        bus.pending_count_out   = count_q;
    end

    always_comb begin
        mcand_mem_d  = mcand_mem_q;
        mplier_mem_d = mplier_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CW'(w_push) - CW'(w_pop);
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        result_d     = result_q;
        result_ovf_d = result_ovf_q;
        timeout_d    = timeout_q;
        done_prev_d  = bus.done_in;

        if (w_push) begin
            mcand_mem_d[wr_ptr_q]  = bus.multiplicand_data_in;
            mplier_mem_d[wr_ptr_q] = bus.multiplier_data_in;
            wr_ptr_d               = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            mcand_d   = mcand_mem_q[rd_ptr_q];
            mplier_d  = mplier_mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + AW'(1);
            timeout_d = 1'b0;
        end
        if (w_done_rise) begin
            result_d     = bus.product_in;
            result_ovf_d = bus.overflow_in;
            timeout_d    = 1'b0;
        end else if (w_timeout) begin
            result_d     = '0;
            result_ovf_d = 1'b0;
            timeout_d    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            mcand_mem_q  <= '{default: '0};
            mplier_mem_q <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            result_q     <= '0;
            result_ovf_q <= 1'b0;
            timeout_q    <= 1'b0;
            done_prev_q  <= 1'b0;
        end else begin
            mcand_mem_q  <= mcand_mem_d;
            mplier_mem_q <= mplier_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            result_q     <= result_d;
            result_ovf_q <= result_ovf_d;
            timeout_q    <= timeout_d;
            done_prev_q  <= done_prev_d;
        end
    end
endmodule
`default_nettype wire

// File: doc/mult_operand_dispatcher.md
MULT_OPERAND_DISPATCHER -- requirements
Module: mult_operand_dispatcher

Interface
REQ-001 Parameter WIDTH, default 8, operand width; product width is 2*WIDTH.
REQ-002 Parameter DEPTH, default 4, operand FIFO entries; power of two, >= 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, watchdog limit in clock cycles (used only under REQ-030).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  sole clock, all state updates on rising edge.
REQ-006 reset_in  input  1  asynchronous active-low reset.
REQ-007 op_valid_in  input  1  upstream operand pair valid.
REQ-008 op_ready_out  output  1  FIFO can accept a pair.
REQ-009 multiplicand_data_in / multiplier_data_in  input  WIDTH each  operand pair from upstream.
REQ-010 multiplicand_out / multiplier_out  output  WIDTH each  operands driven to the sequential multiplier.
REQ-011 start_out  output  1  start level to the multiplier.
REQ-012 done_in / overflow_in  input  1 each  multiplier completion and overflow flag.
REQ-013 product_in  input  2*WIDTH  multiplier product.
REQ-014 result_valid_out  output  1, result_ready_in  input  1  result handshake.
REQ-015 result_out  output  2*WIDTH, result_overflow_out  output  1  captured product and flag.
REQ-016 pending_count_out  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 timeout_out  output  1  set when the watchdog aborted the current job.

Function
REQ-018 FIFO push when op_valid_in && op_ready_out; op_ready_out = (count != DEPTH), combinational from count only.
REQ-019 Push and pop in the same cycle both take effect; count unchanged; pointers wrap modulo DEPTH.
REQ-020 FSM states IDLE, LOAD, BUSY, HOLD.
REQ-021 IDLE: FIFO non-empty -> pop head into multiplicand_out/multiplier_out, go LOAD; else stay.
REQ-022 LOAD: one cycle, operands stable, start_out low; go BUSY.
REQ-023 BUSY: start_out high, held until done capture; operands unchanged throughout.
REQ-024 Done capture on rising edge of done_in (done_in=1 while registered previous done_in=0); product_in and overflow_in are sampled on that clock edge into result_out/result_overflow_out; start_out drops the next cycle; go HOLD.
REQ-025 done_in already high on entry to BUSY is ignored until it falls and rises again.
REQ-026 HOLD: result_valid_out high; result_out, result_overflow_out and timeout_out stable while result_ready_in low; on accept go IDLE.
REQ-027 Minimum issue-to-issue spacing: LOAD + BUSY (>= 1 cycle) + HOLD (>= 1 cycle) + IDLE = 4 cycles plus multiplier latency.
REQ-028 FIFO pushes continue in every state.

Reset
REQ-029 reset_in low: immediately and asynchronously set state IDLE, FIFO empty (pending_count_out=0), op_ready_out=1, start_out=0, result_valid_out=0, result_out=0, result_overflow_out=0, timeout_out=0, operand outputs 0; in-flight and queued jobs are discarded.

Configuration
REQ-030 Macro MULT_DISPATCH_TIMEOUT_EN defined: cycle counter cleared on BUSY entry; reaching TIMEOUT_CYCLES in BUSY without capture -> result_out=0, result_overflow_out=0, timeout_out=1, start_out low, go HOLD.
REQ-031 Macro undefined: no counter; BUSY waits indefinitely; timeout_out tied 0.

Verification (WIDTH=8, DEPTH=4)
REQ-032 Push 3 x 5; model done_in 8 cycles after start -> result_out=0x000F, overflow 0, start_out high exactly from BUSY entry to capture.
REQ-033 Hold multiplier busy, push 5 pairs back-to-back -> op_ready_out low after 4th push, pending_count_out=4, 5th pair is accepted only after a pop.
REQ-034 Result 255 x 255 with overflow_in=1, result_ready_in low 10 cycles -> result_out=0xFE01, result_overflow_out=1, both stable; no new start_out until accepted.
REQ-035 Assert reset_in low mid-BUSY with 2 pairs queued -> start_out low the same cycle, pending_count_out=0, result_valid_out=0; no result emerges after release.
REQ-036 MULT_DISPATCH_TIMEOUT_EN defined, done_in held low -> after 64 BUSY cycles timeout_out=1, result_out=0, result_valid_out=1; next queued pair then issues normally.
